// File: rtl/fitness_pkg.sv
// Shared types and sizing helpers for the serial fitness evaluator.
package fitness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } fit_state_t;

  function automatic int fit_width(input int in_w, input int out_w);
    return $clog2((2 ** in_w) * out_w + 1);
  endfunction

endpackage

// File: rtl/match_count.sv
// Counts output bits of the candidate circuit that agree with the
// target slice for the current input vector.
module match_count #(
  parameter  int OUT = 1,
  localparam int MW  = $clog2(OUT + 1)
) (
  input  logic [OUT-1:0] circ_out_i,
  input  logic [OUT-1:0] tgt_i,
  output logic [MW-1:0]  hits_o
);

  logic [OUT-1:0] eq;

  assign eq = ~(circ_out_i ^ tgt_i);

  always_comb begin
    hits_o = '0;
    for (int k = 0; k < OUT; k++) begin
      hits_o = hits_o + MW'(eq[k]);
    end
  end

endmodule

// File: rtl/fitness_eval.sv
// Sweeps every input vector of the candidate circuit, waits for it to
// settle, and accumulates the number of output bits matching the target.
module fitness_eval
  import fitness_pkg::*;
#(
  parameter  int IN     = 2,
  parameter  int OUT    = 1,
  parameter  int SETTLE = 2,
  localparam int FW     = fit_width(IN, OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [(2**IN)*OUT-1:0] target,
  output logic [IN-1:0]         circ_inp,
  input  logic [OUT-1:0]        circ_out,
  output logic                  busy,
  output logic                  done,
  output logic [FW-1:0]         fitness,
  output logic                  perfect
);

  localparam int NV = 2 ** IN;
  localparam int NB = NV * OUT;
  localparam int MW = $clog2(OUT + 1);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [IN-1:0] VEC_LAST = IN'(NV - 1);
  localparam logic [FW-1:0] FIT_MAX  = FW'(NB);

  fit_state_t state_q, state_d;
  logic [IN-1:0] vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fit_q, fit_d;
  logic [OUT-1:0] tgt_sl;
  logic [MW-1:0] hits;

  assign tgt_sl = target[OUT*int'(vec_q) +: OUT];

  match_count #(
    .OUT (OUT)
  ) u_match (
    .circ_out_i (circ_out),
    .tgt_i      (tgt_sl),
    .hits_o     (hits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fit_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fit_q   <= fit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fit_d   = fit_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT;
          vec_d   = '0;
          fit_d   = '0;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SAMPLE: begin
        fit_d = fit_q + FW'(hits);
        // last-vector test precedes the increment, so vec never wraps
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          vec_d   = vec_q + IN'(1);
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign circ_inp = vec_q;
  assign fitness  = fit_q;
  assign busy     = (state_q == WAIT) || (state_q == SAMPLE);
  assign done     = (state_q == DONE);
  assign perfect  = done && (fit_q == FIT_MAX);

endmodule

// File: tb/tb_fitness_eval.sv
// Bench for fitness_eval: two instances (OUT=1, OUT=2) driven by a
// behavioural candidate circuit and checked against a truth-table model.
module tb_fitness_eval;

  localparam int PER   = 3;
  localparam int EDGES = 4 * PER;

  localparam int M_AND  = 0;
  localparam int M_ZERO = 1;
  localparam int M_SWAP = 2;
  localparam int M_TBL  = 3;

  typedef struct {
    int         which;
    int         mode;
    logic [7:0] tgt;
    int         fit;
    int         perf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [3:0] tgt1 = '0;
  logic [7:0] tgt2 = '0;
  logic [1:0] inp1, inp2;
  logic       out1;
  logic [1:0] out2;
  logic [1:0] c1, c2;
  logic       busy1, done1, perf1;
  logic       busy2, done2, perf2;
  logic [2:0] fit1;
  logic [3:0] fit2;

  int         mode1 = 0;
  int         mode2 = 0;
  logic [7:0] rt1 = '0;
  logic [7:0] rt2 = '0;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;

  logic       s_busy, s_done, s_perf;
  logic [3:0] s_fit;
  logic [1:0] s_inp;

  fitness_eval #(.IN(2), .OUT(1), .SETTLE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .target(tgt1),
    .circ_inp(inp1), .circ_out(out1), .busy(busy1), .done(done1),
    .fitness(fit1), .perfect(perf1)
  );

  fitness_eval #(.IN(2), .OUT(2), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .target(tgt2),
    .circ_inp(inp2), .circ_out(out2), .busy(busy2), .done(done2),
    .fitness(fit2), .perfect(perf2)
  );

  function automatic logic [1:0] circ_val(input int which, input int mode,
                                          input logic [1:0] v,
                                          input logic [7:0] rt);
    case (mode)
      M_AND:  return which != 0 ? v : {1'b0, v[1] & v[0]};
      M_ZERO: return 2'b00;
      M_SWAP: return {v[0], v[1]};
      default:
        return which != 0 ? rt[int'(v)*2 +: 2] : {1'b0, rt[int'(v)]};
    endcase
  endfunction

  function automatic int ref_fit(input int which, input int mode,
                                 input logic [7:0] tgt, input logic [7:0] rt);
    int nout;
    int n;
    logic [1:0] o;
    nout = (which != 0) ? 2 : 1;
    n = 0;
    for (int v = 0; v < 4; v++) begin
      o = circ_val(which, mode, 2'(v), rt);
      for (int k = 0; k < nout; k++)
        if (o[k] == tgt[v*nout + k]) n++;
    end
    return n;
  endfunction

  always_comb c1 = circ_val(0, mode1, inp1, rt1);
  always_comb c2 = circ_val(1, mode2, inp2, rt2);
  assign out1 = c1[0];
  assign out2 = c2;

  always_comb begin
    if (sel != 0) begin
      s_busy = busy2; s_done = done2; s_perf = perf2;
      s_fit = fit2; s_inp = inp2;
    end else begin
      s_busy = busy1; s_done = done1; s_perf = perf1;
      s_fit = {1'b0, fit1}; s_inp = inp1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl1", {31'd0, busy1 & done1}, 0);
      chk("excl2", {31'd0, busy2 & done2}, 0);
    end
  end

  task automatic run(input int which, input bit hold, output int edges);
    int cyc;
    bit seq_ok;
    sel = which;
    @(negedge clk);
    if (which != 0) start2 = 1'b1;
    else start1 = 1'b1;
    cyc = 0;
    seq_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_rise", {31'd0, s_busy}, 1);
        chk("done_drop", {31'd0, s_done}, 0);
        chk("fit_clear", {28'd0, s_fit}, 0);
        if (!hold) begin
          start1 = 1'b0;
          start2 = 1'b0;
        end
      end
      if (s_busy && s_inp !== 2'((cyc - 1) / PER)) seq_ok = 1'b0;
    end while (!s_done && cyc < 200);
    edges = cyc - 1;
    chk("inp_seq", {31'd0, seq_ok}, 1);
  endtask

  initial begin
    vec_t tbl[7];
    int edges;
    int exp;
    int w;
    int cyc;

    tbl[0] = '{0, M_AND,  8'h08, 4, 1};
    tbl[1] = '{0, M_ZERO, 8'h08, 3, 0};
    tbl[2] = '{0, M_AND,  8'h07, 0, 0};
    tbl[3] = '{1, M_AND,  8'hE4, 8, 1};
    tbl[4] = '{1, M_SWAP, 8'hE4, 4, 0};
    tbl[5] = '{1, M_ZERO, 8'h00, 8, 1};
    tbl[6] = '{1, M_ZERO, 8'hE4, 4, 0};

    repeat (2) @(negedge clk);
    chk("rst_busy1", {31'd0, busy1}, 0);
    chk("rst_done1", {31'd0, done1}, 0);
    chk("rst_fit1", {29'd0, fit1}, 0);
    chk("rst_inp1", {30'd0, inp1}, 0);
    chk("rst_perf1", {31'd0, perf1}, 0);
    chk("rst_done2", {31'd0, done2}, 0);
    chk("rst_fit2", {28'd0, fit2}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].which != 0) begin
        mode2 = tbl[i].mode; tgt2 = tbl[i].tgt;
      end else begin
        mode1 = tbl[i].mode; tgt1 = tbl[i].tgt[3:0];
      end
      run(tbl[i].which, 1'b0, edges);
      chk($sformatf("t%0d_edges", i), edges, EDGES);
      chk($sformatf("t%0d_fit", i), {28'd0, s_fit}, tbl[i].fit);
      chk($sformatf("t%0d_perf", i), {31'd0, s_perf}, tbl[i].perf);
    end

    // asynchronous reset in the middle of a sweep
    sel = 0; mode1 = M_AND; tgt1 = 4'b1000;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy1}, 0);
    chk("ar_fit", {29'd0, fit1}, 0);
    chk("ar_inp", {30'd0, inp1}, 0);
    chk("ar_done2", {31'd0, done2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b0, edges);
    chk("ar_edges", edges, EDGES);
    chk("ar_fit_after", {28'd0, s_fit}, 4);
    chk("ar_perf_after", {31'd0, s_perf}, 1);

    // start held high for the whole sweep
    mode1 = M_ZERO;
    run(0, 1'b1, edges);
    chk("hold_edges", edges, EDGES);
    chk("hold_fit", {28'd0, s_fit}, 3);
    @(negedge clk);
    chk("hold_restart_busy", {31'd0, busy1}, 1);
    chk("hold_restart_done", {31'd0, done1}, 0);
    chk("hold_restart_fit", {29'd0, fit1}, 0);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_second_fit", {29'd0, fit1}, 3);

    // random truth tables against the model
    for (int i = 0; i < 10; i++) begin
      w = i % 2;
      if (w != 0) begin
        mode2 = M_TBL; rt2 = 8'($urandom); tgt2 = 8'($urandom);
        exp = ref_fit(1, M_TBL, tgt2, rt2);
      end else begin
        mode1 = M_TBL; rt1 = 8'($urandom); tgt1 = 4'($urandom);
        exp = ref_fit(0, M_TBL, {4'd0, tgt1}, rt1);
      end
      run(w, 1'b0, edges);
      chk($sformatf("r%0d_edges", i), edges, EDGES);
      chk($sformatf("r%0d_fit", i), {28'd0, s_fit}, exp);
      chk($sformatf("r%0d_perf", i), {31'd0, s_perf},
          (exp == (w != 0 ? 8 : 4)) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fitness_eval.md
# fitness_eval

Sequential fitness evaluator sitting directly downstream of the genotype evaluator (`newGenetico`) in the serial genetic circuit. It sweeps every input vector of the candidate circuit and waits a fixed settle time per vector. It compares the circuit outputs against a target truth table and accumulates the count of matching output bits. The result is the fitness score consumed by the genetic search controller.

## Interface
- `IN`, 2: candidate circuit input count; sweep covers 2**IN vectors.
- `OUT`, 1: candidate circuit output count.
- `SETTLE`, 2: cycles each vector is held before sampling; legal range is ≥1.
- `FW`, $clog2(2**IN*OUT+1): fitness width; localparam, not overridable.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin evaluation; honoured only in IDLE or DONE.
- `target`  in  2**IN*OUT  expected truth table; bit `vec*OUT+k` is output k for input vector vec. Must be stable while busy.
- `circ_inp`  out  IN  drives the candidate circuit's `inp`.
- `circ_out`  in  OUT  candidate circuit's `out`; combinational from `circ_inp`.
- `busy`  out  1  high in WAIT and SAMPLE.
- `done`  out  1  high in DONE; held until the next start or reset.
- `fitness`  out  FW  count of matching bits; final value is valid while `done` is high.
- `perfect`  out  1  high in DONE when fitness == 2**IN*OUT.

## Operation
- The FSM has four states: IDLE, WAIT, SAMPLE, DONE.
- Reset values: state=IDLE, vec=0, settle counter=0, `circ_inp`=0, `fitness`=0, `busy`=0, `done`=0, `perfect`=0.
- IDLE or DONE with `start`=1:
  - clear vec to 0 and fitness to 0;
  - load the settle counter with SETTLE-1;
  - go to WAIT.
- WAIT:
  - `circ_inp`=vec (registered);
  - decrement the counter each cycle;
  - when the counter is 0, go to SAMPLE.
- SAMPLE:
  - on the edge, add popcount(~(circ_out ^ target[vec*OUT +: OUT])) to fitness;
  - if vec == 2**IN-1, go to DONE;
  - otherwise increment vec, reload the counter with SETTLE-1, and go to WAIT.
- DONE: `fitness` and `perfect` hold, and `circ_inp` holds the last vector.
- `start` is ignored in WAIT and SAMPLE; there is no abort.
- Arithmetic: fitness is unsigned, width FW, and cannot overflow (maximum is 2**IN*OUT). Vec is IN bits wide; wrap-around is never reached because the last-vector check precedes the increment.
- Asserting `rst_n` mid-sweep returns the block to the reset values immediately (asynchronously). The partial fitness is discarded.
- Simultaneous `start` and the transition into DONE: `start` has no effect. DONE must be observed for ≥1 cycle before a restart.

## Timing
- Each vector occupies SETTLE cycles in WAIT plus 1 cycle in SAMPLE.
- `busy` rises on the cycle after `start` is sampled.
- `done` rises exactly 2**IN*(SETTLE+1) cycles after the `start` edge; `busy` falls on the same edge.
- Restart from DONE drops `done` and raises `busy` on the next edge, with fitness already cleared.
- `circ_inp` changes only on WAIT entry. The downstream circuit path from `circ_inp` to `circ_out` must meet a delay of SETTLE cycles; it is treated as a multicycle path.

## Structure
- Shared package `fitness_pkg`:
  - state enum `fit_state_t` (IDLE, WAIT, SAMPLE, DONE);
  - function `fit_width(in, out)` returning FW.
- One sub-module, `match_count`: a combinational OUT-bit popcount of XNOR(circ_out, target slice), returning $clog2(OUT+1) bits.
- The top level contains the FSM, vec counter, settle counter and fitness accumulator.

## Test plan
- IN=2, OUT=1, SETTLE=2, target=4'b1000, bench circuit = AND; pulse start → `done` 12 cycles later, fitness=4, perfect=1.
- Same setup, circuit tied to 0 → fitness=3, perfect=0.
- IN=2, OUT=2, target=8'hE4, circuit out={in[1],in[0]} (identity) → fitness=8, perfect=1. Then swap to out={in[0],in[1]} and restart from DONE → fitness=4, done drops for 12 cycles.
- Pulse `rst_n` low at cycle 5 of a sweep → all outputs return to 0 immediately. A later start gives a full, correct result.
- Hold `start` high throughout the sweep → no restart mid-sweep; fitness is correct; a new sweep begins the cycle after DONE is first observed.
- Check that `circ_inp` steps 0,1,2,3, each held exactly SETTLE+1 cycles, and that `busy` and `done` are never both high.
